// File: rtl/jtopl_slot_wr_pkg.sv
// Shared definitions for the slot-aligned register write scheduler:
// register classes, slot position layout and operator-offset decoding.
package jtopl_slot_wr_pkg;

    localparam logic [2:0] CLS_AMVIB = 3'b001;
    localparam logic [2:0] CLS_KSLTL = 3'b010;
    localparam logic [2:0] CLS_ARDR  = 3'b011;
    localparam logic [2:0] CLS_SLRR  = 3'b100;
    localparam logic [2:0] CLS_WS    = 3'b111;

    typedef struct packed {
        logic [1:0] grp;
        logic [2:0] sub;
    } slot_pos_t;

    typedef struct packed {
        slot_pos_t  pos;
        logic [2:0] cls;
        logic [7:0] data;
    } wr_entry_t;

    // True for addresses that name an operator register in one of the
    // per-operator classes; channel registers and unused offsets fail.
    function automatic logic op_addr_valid(input logic [7:0] a);
        logic cls_ok;
        case (a[7:5])
            CLS_AMVIB, CLS_KSLTL, CLS_ARDR, CLS_SLRR, CLS_WS: cls_ok = 1'b1;
            default:                                         cls_ok = 1'b0;
        endcase
        return cls_ok && (a[4:3] != 2'b11) && (a[2:0] < 3'd6);
    endfunction

endpackage

// File: rtl/jtopl_slot_wr_fifo.sv
// Generic synchronous FIFO; the head word is read combinationally from the
// storage array so the consumer can compare it in the same cycle.
module jtopl_slot_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves this edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/jtopl_slot_wr.sv
// Queues CPU operator-register writes and presents each one to the register
// banks during the slot of its target operator, strictly in arrival order.
module jtopl_slot_wr
    import jtopl_slot_wr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [1:0] group,
    input  logic [2:0] subslot,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic       busy,
    output logic       full,
    output logic       ovr,
    output logic       upd_valid,
    output logic [2:0] upd_sel,
    output logic [7:0] upd_data
);
    localparam int AW = $clog2(DEPTH);

    wr_entry_t   push_entry;
    wr_entry_t   head_entry;
    slot_pos_t   cur_pos;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        ovr_reg;

    assign push_entry.pos.grp = addr[4:3];
    assign push_entry.pos.sub = addr[2:0];
    assign push_entry.cls     = addr[7:5];
    assign push_entry.data    = din;

    assign cur_pos.grp = group;
    assign cur_pos.sub = subslot;

    assign push = write && op_addr_valid(addr);
    assign pop  = cen && upd_valid;

    jtopl_slot_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wr_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy      = !fifo_empty;
    assign full      = fifo_full;
    assign upd_valid = busy && (head_entry.pos == cur_pos);
    assign upd_sel   = busy ? head_entry.cls  : 3'd0;
    assign upd_data  = busy ? head_entry.data : 8'd0;
    assign ovr       = ovr_reg;

    // Only a push that the FIFO really refuses counts as an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr_reg <= 1'b0;
        else if (push && (fifo_count == (AW+1)'(DEPTH)) && !pop)
            ovr_reg <= 1'b1;
    end

endmodule

// File: tb/tb_jtopl_slot_wr.sv
// Directed and randomized checks of jtopl_slot_wr against a queue-based model
// of slot-aligned write delivery, driven by a modelled 18-slot counter.
module tb_jtopl_slot_wr;
    localparam int DEPTH = 4;
    localparam int NSLOT = 18;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic [1:0] group = '0;
    logic [2:0] subslot = '0;
    logic       write = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] din = '0;
    logic       busy, full, ovr, upd_valid;
    logic [2:0] upd_sel;
    logic [7:0] upd_data;

    jtopl_slot_wr #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .group     (group),
        .subslot   (subslot),
        .write     (write),
        .addr      (addr),
        .din       (din),
        .busy      (busy),
        .full      (full),
        .ovr       (ovr),
        .upd_valid (upd_valid),
        .upd_sel   (upd_sel),
        .upd_data  (upd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p;
        logic [2:0] cls;
        logic [7:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_ovr = 1'b0;
    int   pos = 0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic bit addr_ok(logic [7:0] a);
        int c = int'(a[7:5]);
        return (c == 1 || c == 2 || c == 3 || c == 4 || c == 7) &&
               (int'(a[4:3]) <= 2) && (int'(a[2:0]) <= 5);
    endfunction

    function automatic int addr_pos(logic [7:0] a);
        return int'(a[4:3]) * 6 + int'(a[2:0]);
    endfunction

    task automatic set_pos(int p);
        pos     = p;
        group   = 2'(p / 6);
        subslot = 3'(p % 6);
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit         e_busy = (q.size() != 0);
        bit         e_valid = e_busy && (q[0].p == pos);
        logic [2:0] e_sel = e_busy ? q[0].cls : 3'd0;
        logic [7:0] e_data = e_busy ? q[0].d : 8'd0;
        chk({tag, "_busy"},  8'(busy),      8'(e_busy));
        chk({tag, "_full"},  8'(full),      8'(q.size() == DEPTH));
        chk({tag, "_ovr"},   8'(ovr),       8'(m_ovr));
        chk({tag, "_valid"}, 8'(upd_valid), 8'(e_valid));
        chk({tag, "_sel"},   8'(upd_sel),   8'(e_sel));
        chk({tag, "_data"},  upd_data,      e_data);
    endtask

    // One clk: drive inputs, update the model at the edge, advance the slot
    // counter on cen, then compare all outputs.
    task automatic cyc(string tag, bit w, logic [7:0] a, logic [7:0] d, bit c);
        bit hv;
        bit pop;
        int sz;
        write = w; addr = a; din = d; cen = c;
        @(posedge clk);
        sz  = q.size();
        hv  = (sz != 0) && (q[0].p == pos);
        pop = c && hv;
        if (pop)
            void'(q.pop_front());
        if (w && addr_ok(a)) begin
            if (sz < DEPTH || pop)
                q.push_back('{p: addr_pos(a), cls: a[7:5], d: d});
            else
                m_ovr = 1'b1;
        end
        #1;
        write = 1'b0; cen = 1'b0;
        if (c)
            set_pos((pos + 1) % NSLOT);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(string tag);
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_ovr = 1'b0;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] five_addr [5];
        logic [7:0] a;
        five_addr[0] = 8'h21; five_addr[1] = 8'h2A; five_addr[2] = 8'h33;
        five_addr[3] = 8'h44; five_addr[4] = 8'h55;

        set_pos(0);
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Write to g0/s0 while at g0/s3: delivered 15 cen later.
        set_pos(3);
        cyc("t1_wr", 1'b1, 8'h20, 8'h5A, 1'b0);
        for (int i = 0; i < 14; i++) cyc("t1_wait", 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t1_early", 8'(upd_valid), 8'd0);
        cyc("t1_arrive", 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t1_valid", 8'(upd_valid), 8'd1);
        chk("t1_sel", 8'(upd_sel), 8'd1);
        chk("t1_data", upd_data, 8'h5A);
        cyc("t1_retire", 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t1_busy", 8'(busy), 8'd0);

        // g2/s5 target plus two ignored addresses.
        cyc("t2_wr", 1'b1, 8'h55, 8'h11, 1'b0);
        cyc("t2_bad0", 1'b1, 8'hA0, 8'h99, 1'b0);
        cyc("t2_bad1", 1'b1, 8'h26, 8'h98, 1'b0);
        for (int i = 0; i < 2 * NSLOT; i++) cyc("t2_run", 1'b0, 8'h00, 8'h00, 1'b1);
        cyc("t2_bad2", 1'b1, 8'hA0, 8'h97, 1'b0);
        chk("t2_busy", 8'(busy), 8'd0);

        // Head-of-line: g0/s0 then g1/s0 while sitting at g1/s0.
        set_pos(6);
        cyc("t3_wr0", 1'b1, 8'h40, 8'hC1, 1'b0);
        cyc("t3_wr1", 1'b1, 8'h48, 8'hC2, 1'b0);
        chk("t3_hol", 8'(upd_valid), 8'd0);
        for (int i = 0; i < 12 + 1 + 6; i++) cyc("t3_run", 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t3_busy", 8'(busy), 8'd0);

        // Five writes to non-matching slots: overflow on the fifth.
        set_pos(0);
        for (int i = 0; i < 5; i++) begin
            cyc("t4_wr", 1'b1, five_addr[i], 8'(8'h10 + i), 1'b0);
            if (i == 3) chk("t4_full", 8'(full), 8'd1);
        end
        chk("t4_ovr", 8'(ovr), 8'd1);
        for (int i = 0; i < 2 * NSLOT; i++) cyc("t4_run", 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t4_drained", 8'(busy), 8'd0);
        chk("t4_ovr_sticky", 8'(ovr), 8'd1);

        // Reset with three entries pending.
        set_pos(0);
        cyc("t6_wr", 1'b1, 8'h61, 8'hA1, 1'b0);
        cyc("t6_wr", 1'b1, 8'h62, 8'hA2, 1'b0);
        cyc("t6_wr", 1'b1, 8'h63, 8'hA3, 1'b0);
        set_pos(1);
        #1;
        chk("t6_pre_valid", 8'(upd_valid), 8'd1);
        do_reset("t6_rst");
        for (int i = 0; i < 2 * NSLOT; i++) cyc("t6_run", 1'b0, 8'h00, 8'h00, 1'b1);

        // Full queue, head matches on cen, simultaneous valid write.
        set_pos(10);
        cyc("t5_wr", 1'b1, 8'h21, 8'hB0, 1'b0);
        cyc("t5_wr", 1'b1, 8'h41, 8'hB1, 1'b0);
        cyc("t5_wr", 1'b1, 8'h61, 8'hB2, 1'b0);
        cyc("t5_wr", 1'b1, 8'h81, 8'hB3, 1'b0);
        set_pos(1);
        #1;
        cyc("t5_swap", 1'b1, 8'hE2, 8'h77, 1'b1);
        chk("t5_full", 8'(full), 8'd1);
        chk("t5_ovr", 8'(ovr), 8'd0);
        for (int i = 0; i < 4 * NSLOT; i++) cyc("t5_run", 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t5_busy", 8'(busy), 8'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                case ($urandom_range(4, 0))
                    0: a[7:5] = 3'b001;
                    1: a[7:5] = 3'b010;
                    2: a[7:5] = 3'b011;
                    3: a[7:5] = 3'b100;
                    default: a[7:5] = 3'b111;
                endcase
                a[4:0] = 5'($urandom);
            end else begin
                a = 8'($urandom);
            end
            cyc("rnd", ($urandom_range(2, 0) == 0), a, 8'($urandom),
                ($urandom_range(3, 0) != 0));
            if (i == 700) do_reset("rnd_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
